// File: rtl/cross_bar_slave_ram.sv
// Memory-backed crossbar slave endpoint. It captures a request, waits a fixed
// number of cycles, then performs the RAM access and returns a one-cycle ack.
module cross_bar_slave_ram #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SLAVE_W     = 2,
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              slave_err,
  output logic [1:0]        dbg_state
);

  localparam int          LOC_W     = ADDR_W - SLAVE_W;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [31:0] BAD_WORD  = 32'hBAD0ADD5;

  // Handshake: slave_req is held by the master until it sees slave_ack; the
  // slave accepts only in IDLE and re-arms only after req has been seen low.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [LOC_W-1:0]    addr_q, addr_d;
  logic                cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]   idx;
  logic                out_of_range;
  logic                resp_fire;
  logic                mem_we;
  logic                unused_addr_hi;

  // Slave-select bits were decoded by the crossbar and carry no meaning here.
  assign unused_addr_hi = ^slave_addr[ADDR_W-1:LOC_W];

  assign idx          = addr_q[MEM_AW+1:2];
  assign out_of_range = (addr_q[LOC_W-1:MEM_AW+2] != '0) || (addr_q[1:0] != 2'b00);
  // RESP lasts two cycles: the first edge performs the access, the second clears ack.
  assign resp_fire    = (state_q == ST_RESP) && !ack_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (slave_req) begin
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ack_q) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!slave_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = resp_fire;
    err_d   = resp_fire && out_of_range;
    mem_we  = resp_fire && cmd_q && !out_of_range && aresetn;
    if ((state_q == ST_IDLE) && slave_req) begin
      addr_d  = slave_addr[LOC_W-1:0];
      cmd_d   = slave_cmd;
      wdata_d = slave_wdata;
    end
    if (resp_fire && !cmd_q) begin
      rdata_d = out_of_range ? DATA_W'(BAD_WORD) : mem_q[idx];
    end
  end

  assign slave_ack   = ack_q;
  assign slave_err   = err_q;
  assign slave_rdata = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cross_bar_slave_ram.sv
// Bench for cross_bar_slave_ram: three instances (wait 2, 0, 5) driven by
// directed tables and random traffic, checked against a word-level RAM model.
module tb_cross_bar_slave_ram;

  localparam int          N        = 3;
  localparam logic [31:0] BAD_WORD = 32'hBAD0ADD5;

  typedef struct {
    int          inst;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
  } op_t;

  int waits [N] = '{2, 0, 5};
  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        req   [N];
  logic        cmd   [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic        ack   [N];
  logic        err   [N];
  logic [31:0] rdata [N];
  logic [1:0]  dbg   [N];

  logic [31:0] mem_m [int];
  logic [31:0] last_rd [N];

  always #5 clk = ~clk;

  cross_bar_slave_ram #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .aresetn(aresetn), .slave_req(req[0]), .slave_addr(addr[0]),
    .slave_cmd(cmd[0]), .slave_wdata(wdata[0]), .slave_ack(ack[0]),
    .slave_rdata(rdata[0]), .slave_err(err[0]), .dbg_state(dbg[0])
  );

  cross_bar_slave_ram #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .aresetn(aresetn), .slave_req(req[1]), .slave_addr(addr[1]),
    .slave_cmd(cmd[1]), .slave_wdata(wdata[1]), .slave_ack(ack[1]),
    .slave_rdata(rdata[1]), .slave_err(err[1]), .dbg_state(dbg[1])
  );

  cross_bar_slave_ram #(.WAIT_CYCLES(5)) u_dut_w5 (
    .clk(clk), .aresetn(aresetn), .slave_req(req[2]), .slave_addr(addr[2]),
    .slave_cmd(cmd[2]), .slave_wdata(wdata[2]), .slave_ack(ack[2]),
    .slave_rdata(rdata[2]), .slave_err(err[2]), .dbg_state(dbg[2])
  );

  // ---------------- reference model ----------------
  // 256-word RAM behind a byte address; the two slave-select MSBs are ignored.
  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] local_a;
    local_a = a & 32'h3FFF_FFFF;
    return (local_a < 32'd1024) && ((a % 4) == 0);
  endfunction

  function automatic int key(input int inst, input logic [31:0] a);
    return inst * 4096 + int'((a & 32'h3FF) / 4);
  endfunction

  task automatic model(input int inst, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] exp_rd,
                       output logic exp_err);
    exp_err = !in_range(a);
    if (!exp_err && wr)       mem_m[key(inst, a)] = wd;
    else if (!exp_err && !wr) last_rd[inst] = mem_m[key(inst, a)];
    else if (exp_err && !wr)  last_rd[inst] = BAD_WORD;
    exp_rd = last_rd[inst];
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
  endtask

  // One full transaction; request inputs are scrambled after acceptance so a
  // design that re-samples them late returns the wrong result.
  task automatic access(input int inst, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int extra);
    bit got;
    got   = 1'b0;
    rd    = '0;
    er    = 1'b0;
    lat   = -1;
    extra = 0;
    @(negedge clk);
    cmd[inst]   = wr;
    addr[inst]  = a;
    wdata[inst] = wd;
    req[inst]   = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        cmd[inst]   = ~wr;
        addr[inst]  = ~a;
        wdata[inst] = ~wd;
      end
      if (ack[inst] === 1'b1) begin
        got = 1'b1;
        lat = k;
        rd  = rdata[inst];
        er  = err[inst];
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout inst=%0d addr=%h got=no_ack exp=ack", inst, a);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (ack[inst] !== 1'b0) extra++;
    end
    req[inst] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ack[inst] !== 1'b0) extra++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      total++; if (ack[i] !== 1'b0) begin bad++; $display("FAIL reset_ack inst=%0d got=%b exp=0", i, ack[i]); end
      total++; if (err[i] !== 1'b0) begin bad++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, err[i]); end
      total++; if (rdata[i] !== 32'h0) begin bad++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", i, rdata[i]); end
    end
  endtask

  task automatic test_directed(input string name, input op_t ops[$]);
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, extra;
    foreach (ops[i]) begin
      access(ops[i].inst, ops[i].wr, ops[i].a, ops[i].wd, ops[i].hold, rd, er, lat, extra);
      model(ops[i].inst, ops[i].wr, ops[i].a, ops[i].wd, erd, eer);
      total++; if (lat != waits[ops[i].inst] + 1) begin bad++; $display("FAIL %s_latency op=%0d got=%0d exp=%0d", name, i, lat, waits[ops[i].inst] + 1); end
      total++; if (er !== eer) begin bad++; $display("FAIL %s_err op=%0d got=%b exp=%b", name, i, er, eer); end
      total++; if (rd !== erd) begin bad++; $display("FAIL %s_rdata op=%0d got=%h exp=%h", name, i, rd, erd); end
      total++; if (extra != 0) begin bad++; $display("FAIL %s_single_ack op=%0d got=%0d extra acks exp=0", name, i, extra); end
    end
  endtask

  task automatic test_basic();
    op_t ops[$];
    ops = '{
      '{0, 1'b1, 32'hA000_0000, 32'hDEAD_C0DE, 0},
      '{0, 1'b0, 32'hA000_0000, 32'h0,         0},
      '{0, 1'b1, 32'hC000_0000, 32'hDEAD_C0DE, 0},
      '{0, 1'b0, 32'hC000_0000, 32'h0,         1},
      '{0, 1'b1, 32'hD200_0004, 32'h0F0F_0F0F, 0},
      '{0, 1'b1, 32'hD200_0008, 32'h1234_5678, 0},
      '{0, 1'b0, 32'hD200_0008, 32'h0,         0},
      '{0, 1'b0, 32'hD200_0004, 32'h0,         0},
      '{0, 1'b1, 32'h4000_0004, 32'h0F0F_0F0F, 0},
      '{0, 1'b1, 32'h8000_0008, 32'h1234_5678, 2},
      '{0, 1'b0, 32'h0000_0008, 32'h0,         0},
      '{0, 1'b0, 32'hC000_0004, 32'h0,         0}
    };
    test_directed("basic", ops);
  endtask

  task automatic test_wait0();
    op_t ops[$];
    ops = '{
      '{1, 1'b1, 32'h0000_0010, 32'h5A5A_5A5A, 3},
      '{1, 1'b0, 32'h0000_0010, 32'h0,         3},
      '{1, 1'b1, 32'h4000_03FC, 32'h0000_0000, 0},
      '{1, 1'b0, 32'h0000_03FC, 32'h0,         1}
    };
    test_directed("wait0", ops);
  endtask

  task automatic test_out_of_range();
    op_t ops[$];
    ops = '{
      '{0, 1'b1, 32'h0000_0000, 32'h1357_9BDF, 0},
      '{0, 1'b1, 32'h0000_1000, 32'h0000_0055, 0},
      '{0, 1'b0, 32'h0000_1000, 32'h0,         0},
      '{0, 1'b0, 32'h0000_0000, 32'h0,         0},
      '{0, 1'b1, 32'h0000_0002, 32'h0000_0077, 0},
      '{0, 1'b0, 32'h0000_0001, 32'h0,         0},
      '{0, 1'b0, 32'h0000_0000, 32'h0,         0}
    };
    test_directed("oor", ops);
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    ops = '{'{0, 1'b1, 32'h0000_0010, 32'h1111_2222, 0}};
    test_directed("rst_pre", ops);
    @(negedge clk);
    cmd[0]   = 1'b1;
    addr[0]  = 32'h0000_0010;
    wdata[0] = 32'hCAFE_F00D;
    req[0]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        total++; if (ack[i] !== 1'b0) begin bad++; $display("FAIL rst_mid_ack inst=%0d edge=%0d got=%b exp=0", i, e, ack[i]); end
        total++; if (err[i] !== 1'b0) begin bad++; $display("FAIL rst_mid_err inst=%0d edge=%0d got=%b exp=0", i, e, err[i]); end
        total++; if (rdata[i] !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata inst=%0d edge=%0d got=%h exp=0", i, e, rdata[i]); end
      end
    end
    @(negedge clk);
    aresetn = 1'b1;
    req[0]  = 1'b0;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    repeat (2) @(posedge clk);
    ops = '{'{0, 1'b0, 32'h0000_0010, 32'h0, 0}};
    test_directed("rst_post", ops);
  endtask

  task automatic test_drop_mid();
    logic [31:0] erd, wd;
    logic        eer;
    int          acks, first_k;
    op_t         ops[$];
    wd      = $urandom;
    acks    = 0;
    first_k = -1;
    @(negedge clk);
    cmd[2]   = 1'b1;
    addr[2]  = 32'h0000_0020;
    wdata[2] = wd;
    req[2]   = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req[2] = 1'b0;
      if (ack[2] === 1'b1) begin
        acks++;
        if (first_k < 0) first_k = k;
      end
      if (k == 8) begin
        total++; if (dbg[2] !== 2'd0) begin bad++; $display("FAIL drop_idle got=%0d exp=0", dbg[2]); end
      end
    end
    model(2, 1'b1, 32'h0000_0020, wd, erd, eer);
    total++; if (acks != 1) begin bad++; $display("FAIL drop_ack_count got=%0d exp=1", acks); end
    total++; if (first_k != waits[2] + 1) begin bad++; $display("FAIL drop_latency got=%0d exp=%0d", first_k, waits[2] + 1); end
    ops = '{'{2, 1'b0, 32'h0000_0020, 32'h0, 0}};
    test_directed("drop_post", ops);
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    logic [31:0] a;
    ops = {};
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 3) << 30) | ($urandom_range(0, 255) << 2);
      ops.push_back('{i % 2, 1'b1, a, $urandom, 0});
      ops.push_back('{i % 2, 1'b0, a, 32'h0, 0});
      ops.push_back('{i % 2, 1'b1, a, $urandom, 0});
      ops.push_back('{i % 2, 1'b0, a & 32'h3FFF_FFFF, 32'h0, 0});
    end
    test_directed("b2b", ops);
  endtask

  task automatic test_random();
    op_t ops[$];
    logic [31:0] a;
    bit          wr;
    int          sel;
    ops = {};
    for (int inst = 0; inst < N; inst++) begin
      for (int i = 0; i < 25; i++) begin
        sel = $urandom_range(0, 9);
        wr  = $urandom_range(0, 1);
        if (sel <= 6)      a = ($urandom_range(0, 3) << 30) | ($urandom_range(0, 15) << 2);
        else if (sel == 7) a = ($urandom_range(0, 15) << 2) + $urandom_range(1, 3);
        else               a = $urandom | 32'h0000_0400;
        // Never read an in-range word the model has no value for.
        if (!wr && in_range(a) && !mem_m.exists(key(inst, a))) wr = 1'b1;
        ops.push_back('{inst, wr, a, $urandom, $urandom_range(0, 3)});
      end
    end
    test_directed("rand", ops);
  endtask

  initial begin
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i]   = 1'b0;
      cmd[i]   = 1'b0;
      addr[i]  = '0;
      wdata[i] = '0;
      last_rd[i] = '0;
    end
    test_reset();
    test_basic();
    test_wait0();
    test_out_of_range();
    test_reset_mid();
    test_drop_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
